piso_tx_sched: RTL and testbench

Two-requester scheduler and sequencer for a 4-bit parallel-in/serial-out shift register. It accepts parallel words from two independent sources over valid/ready handshakes and arbitrates round-robin between them. It drives load/shift of an internal PISO and emits each word LSB-first as a framed serial stream with source tag. It sits between word producers and a single shared serial line.

---
 rtl/piso_sched_pkg.sv | 14 +
 rtl/piso_shreg.sv | 27 ++
 rtl/piso_tx_sched.sv | 126 ++++++++++++
 tb/tb_piso_tx_sched.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_sched_pkg.sv
// Shared types for the two-requester PISO transmit scheduler.
package piso_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    typedef logic src_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/piso_shreg.sv
// Parallel-in/serial-out shift register; shifts right with zero fill, bit 0 is the serial tap.
module piso_shreg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] par_in,
    output logic             bit0
);

    logic [WIDTH-1:0] sreg_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sreg_q <= '0;
        end else if (load) begin
            sreg_q <= par_in;
        end else if (shift) begin
            sreg_q <= {1'b0, sreg_q[WIDTH-1:1]};
        end
    end

    assign bit0 = sreg_q[0];

endmodule

// File: rtl/piso_tx_sched.sv
// Round-robin arbiter and frame sequencer driving a shared PISO onto one serial line.
module piso_tx_sched
    import piso_sched_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid0,
    input  logic [WIDTH-1:0] data0,
    output logic             ready0,
    input  logic             valid1,
    input  logic [WIDTH-1:0] data1,
    output logic             ready1,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             serial_last,
    output logic             serial_src,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    src_t          ptr_q, ptr_d;
    src_t          cur_src_q, cur_src_d;
    logic          sout_d, svalid_d, slast_d;
    src_t          ssrc_d;
    logic          gnt0, gnt1, load, shift, bit0;
    logic [WIDTH-1:0] par_sel;

    // Pointer only breaks ties; a lone requester is always served.
    assign gnt0 = valid0 & (~valid1 | ~ptr_q);
    assign gnt1 = valid1 & (~valid0 |  ptr_q);

    // Gated by reset_n so no handshake can complete while the block is held in reset.
    assign ready0 = reset_n & (state_q == IDLE) & gnt0;
    assign ready1 = reset_n & (state_q == IDLE) & gnt1;
    assign busy   = (state_q != IDLE);

    assign par_sel = gnt1 ? data1 : data0;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        ptr_d     = ptr_q;
        cur_src_d = cur_src_q;
        sout_d    = 1'b0;
        svalid_d  = 1'b0;
        slast_d   = 1'b0;
        ssrc_d    = serial_src;
        load      = 1'b0;
        shift     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    load      = 1'b1;
                    cur_src_d = gnt1;
                    ptr_d     = gnt0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                shift    = 1'b1;
                sout_d   = bit0;
                svalid_d = 1'b1;
                slast_d  = (cnt_q == CNT_LAST);
                ssrc_d   = cur_src_q;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    gap_d   = '0;
                    state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            gap_q        <= '0;
            ptr_q        <= 1'b0;
            cur_src_q    <= 1'b0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            serial_last  <= 1'b0;
            serial_src   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            ptr_q        <= ptr_d;
            cur_src_q    <= cur_src_d;
            serial_out   <= sout_d;
            serial_valid <= svalid_d;
            serial_last  <= slast_d;
            serial_src   <= ssrc_d;
        end
    end

    piso_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .shift   (shift),
        .par_in  (par_sel),
        .bit0    (bit0)
    );

endmodule

// File: tb/tb_piso_tx_sched.sv
// Scoreboard bench for piso_tx_sched: instance a uses a 1-cycle gap, instance b uses no gap.
module tb_piso_tx_sched;

    localparam int W  = 4;
    localparam int EW = 35;  // {due_cycle[31:0], src, last, bit}

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic v0 [2];
    logic v1 [2];
    logic [W-1:0] d0 [2];
    logic [W-1:0] d1 [2];
    logic r0 [2], r1 [2], so [2], sv [2], sl [2], ss [2], bz [2];

    int unsigned cyc = 0;
    int checks = 0;
    int errors = 0;

    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    int unsigned   free_cyc [2];
    logic          ptr_m [2];
    logic          last_src [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    piso_tx_sched #(.WIDTH(W), .GAP_CYCLES(1)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .valid0(v0[0]), .data0(d0[0]), .ready0(r0[0]),
        .valid1(v1[0]), .data1(d1[0]), .ready1(r1[0]),
        .serial_out(so[0]), .serial_valid(sv[0]), .serial_last(sl[0]),
        .serial_src(ss[0]), .busy(bz[0])
    );

    piso_tx_sched #(.WIDTH(W), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .valid0(v0[1]), .data0(d0[1]), .ready0(r0[1]),
        .valid1(v1[1]), .data1(d1[1]), .ready1(r1[1]),
        .serial_out(so[1]), .serial_valid(sv[1]), .serial_last(sl[1]),
        .serial_src(ss[1]), .busy(bz[1])
    );

    function automatic int gap_of(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    function automatic int q_size(input int k);
        return (k == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [EW-1:0] q_front(input int k);
        return (k == 0) ? exp_q0[0] : exp_q1[0];
    endfunction

    function automatic logic [EW-1:0] q_pop(input int k);
        if (k == 0) return exp_q0.pop_front();
        return exp_q1.pop_front();
    endfunction

    function automatic void q_push(input int k, input logic [EW-1:0] e);
        if (k == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
    endfunction

    function automatic void q_flush(input int k);
        if (k == 0) exp_q0.delete();
        else exp_q1.delete();
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut=%0d cycle=%0d: got %0h, expected %0h", name, k, cyc, act, exp);
        end
    endtask

    // Reference: an idle line grants per round-robin rule; a frame occupies W+gap+1 cycles.
    task automatic model_accept(input int k);
        logic e0, e1, src;
        logic [W-1:0] word;
        e0 = 1'b0;
        e1 = 1'b0;
        chk("busy", k, 32'(bz[k]), 32'(cyc < free_cyc[k]));
        if (cyc >= free_cyc[k] && (v0[k] || v1[k])) begin
            if (v0[k] && (!v1[k] || ptr_m[k] == 1'b0)) e0 = 1'b1;
            else e1 = 1'b1;
        end
        chk("ready0", k, 32'(r0[k]), 32'(e0));
        chk("ready1", k, 32'(r1[k]), 32'(e1));
        if (e0 || e1) begin
            word = e0 ? d0[k] : d1[k];
            src  = e1;
            for (int i = 0; i < W; i++) begin
                q_push(k, {32'(cyc + 2 + i), src, (i == W - 1), word[i]});
            end
            ptr_m[k]    = e0;
            free_cyc[k] = cyc + W + gap_of(k) + 1;
        end
    endtask

    task automatic monitor(input int k);
        logic [EW-1:0] e;
        logic exp_v;
        exp_v = (q_size(k) > 0) && (q_front(k)[34:3] == cyc);
        chk("serial_valid", k, 32'(sv[k]), 32'(exp_v));
        if (exp_v) begin
            e = q_pop(k);
            chk("serial_out", k, 32'(so[k]), 32'(e[0]));
            chk("serial_last", k, 32'(sl[k]), 32'(e[1]));
            chk("serial_src", k, 32'(ss[k]), 32'(e[2]));
            last_src[k] = e[2];
        end else begin
            chk("idle_out_last", k, 32'({so[k], sl[k]}), 32'(0));
            chk("src_hold", k, 32'(ss[k]), 32'(last_src[k]));
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            free_cyc[k] = 0;
            ptr_m[k]    = 1'b0;
            last_src[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!reset_n) begin
                    q_flush(k);
                    ptr_m[k]    = 1'b0;
                    free_cyc[k] = 0;
                    last_src[k] = 1'b0;
                    chk("reset_outputs", k,
                        32'({r0[k], r1[k], so[k], sv[k], sl[k], ss[k], bz[k]}), 32'(0));
                end else begin
                    model_accept(k);
                    monitor(k);
                end
            end
        end
    end

    // Offer one word and hold it until accepted; data is scrambled while valid is low.
    task automatic send(input int k, input int r, input logic [W-1:0] d);
        logic got;
        int t;
        got = 1'b0;
        t = 0;
        if (r == 0) begin v0[k] = 1'b1; d0[k] = d; end
        else begin v1[k] = 1'b1; d1[k] = d; end
        while (!got && t < 200) begin
            @(negedge clk);
            got = (r == 0) ? r0[k] : r1[k];
            t++;
        end
        chk("handshake", k, 32'(got), 32'(1));
        @(posedge clk);
        #1;
        if (r == 0) begin v0[k] = 1'b0; d0[k] = W'($urandom); end
        else begin v1[k] = 1'b0; d1[k] = W'($urandom); end
    endtask

    task automatic rand_stream(input int k, input int r, input int n);
        int m;
        for (int i = 0; i < n; i++) begin
            m = $urandom_range(0, 3);
            if (m > 0) begin
                repeat (m) @(posedge clk);
                #1;
            end
            send(k, r, W'($urandom));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            v0[k] = 1'b1; v1[k] = 1'b1;
            d0[k] = 4'b0100; d1[k] = W'($urandom);
        end
        idle(3);
        reset_n = 1'b1;
        fork
            send(0, 0, 4'b0100);
            send(0, 1, 4'b0110);
            send(1, 0, W'($urandom));
            send(1, 1, W'($urandom));
        join
        idle(8);

        send(0, 0, 4'b0100);
        idle(6);

        fork
            send(0, 0, 4'b1010);
            send(0, 1, 4'b0011);
        join
        idle(8);

        fork
            rand_stream(0, 0, 3);
            rand_stream(0, 1, 3);
        join
        idle(8);

        for (int i = 0; i < 3; i++) send(0, 1, W'($urandom));
        idle(8);

        fork
            rand_stream(0, 0, 20);
            rand_stream(0, 1, 20);
            rand_stream(1, 0, 20);
            rand_stream(1, 1, 20);
        join
        idle(10);

        send(0, 1, 4'b1111);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_reset_valid", 0, 32'(sv[0]), 32'(1));
        reset_n = 1'b0;
        #1;
        chk("async_clear", 0, 32'({sv[0], so[0], bz[0]}), 32'(0));
        idle(2);
        reset_n = 1'b1;
        idle(1);
        chk("post_reset_busy", 0, 32'(bz[0]), 32'(0));
        idle(10);

        send(1, 0, W'($urandom));
        send(1, 0, W'($urandom));
        idle(10);

        chk("queue_empty", 0, 32'(q_size(0)), 32'(0));
        chk("queue_empty", 1, 32'(q_size(1)), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
